// File: rtl/tile_playback_ctrl_pkg.sv
// Shared game definitions: playback state encoding, tile geometry and tile-code/colour constants.
package tile_playback_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_ERASE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int unsigned TILE_PIXELS = 64;
  localparam int unsigned TILE_BITS   = 2;
  localparam int unsigned PIX_W       = 6;

  localparam logic [2:0] BLACK = 3'b000;

  localparam logic [TILE_BITS-1:0] TILE_TOP_LEFT     = 2'b00;
  localparam logic [TILE_BITS-1:0] TILE_TOP_RIGHT    = 2'b01;
  localparam logic [TILE_BITS-1:0] TILE_BOTTOM_LEFT  = 2'b10;
  localparam logic [TILE_BITS-1:0] TILE_BOTTOM_RIGHT = 2'b11;

  localparam logic [2:0] COLOUR_TOP_LEFT     = 3'b001;
  localparam logic [2:0] COLOUR_TOP_RIGHT    = 3'b010;
  localparam logic [2:0] COLOUR_BOTTOM_LEFT  = 3'b011;
  localparam logic [2:0] COLOUR_BOTTOM_RIGHT = 3'b100;

  // Colour the lookup paints for a given tile code.
  function automatic logic [2:0] tile_colour(input logic [TILE_BITS-1:0] code);
    logic [2:0] colour;
    colour = BLACK;
    case (code)
      TILE_TOP_LEFT:     colour = COLOUR_TOP_LEFT;
      TILE_TOP_RIGHT:    colour = COLOUR_TOP_RIGHT;
      TILE_BOTTOM_LEFT:  colour = COLOUR_BOTTOM_LEFT;
      TILE_BOTTOM_RIGHT: colour = COLOUR_BOTTOM_RIGHT;
      default:           colour = BLACK;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/tile_playback_ctrl_raster.sv
// 8x8 tile raster: pixel counter (x fastest) shared by the paint and erase passes.
module tile_raster
  import tile_playback_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [PIX_W-1:0] pixel,
  output logic             last_c
);

  // Wraps naturally to 0 after the last pixel so the next pass starts clean.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pixel <= '0;
    end else if (enable) begin
      pixel <= pixel + PIX_W'(1);
    end
  end

  assign last_c = (pixel == PIX_W'(TILE_PIXELS - 1));

endmodule

// File: rtl/tile_playback_ctrl.sv
// Plays a latched colour sequence tile by tile: paint, hold, erase, gap, then a one-cycle done.
module tile_playback_ctrl
  import tile_playback_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 12_500_000,
  parameter int unsigned MAX_TILES   = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  level,
  input  logic [17:0] seq_in,
  output logic [17:0] seq_out,
  output logic [5:0]  counter,
  output logic        load_random,
  output logic [2:0]  x_off,
  output logic [2:0]  y_off,
  output logic        blank,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TIMER_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW        = ($clog2(TIMER_MAX) < 1) ? 1 : $clog2(TIMER_MAX);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [3:0]      len_q, len_d;
  logic [17:0]     seq_q, seq_d;
  logic [3:0]      level_clamped;
  logic            ras_clr, ras_en, ras_last;
  logic [PIX_W-1:0] pixel;
  logic            plot_d, blank_d, busy_d, done_d;
  logic            plot_q, blank_q, busy_q, done_q;

  tile_raster u_raster (
    .clock  (clock),
    .reset  (reset),
    .clear  (ras_clr),
    .enable (ras_en),
    .pixel  (pixel),
    .last_c (ras_last)
  );

  assign level_clamped = (level > 4'(MAX_TILES)) ? 4'(MAX_TILES) : level;

  // State, counters and output flags; flags are decoded from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      seq_q   <= '0;
      plot_q  <= 1'b0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
      plot_q  <= plot_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    seq_d   = seq_q;
    ras_clr = 1'b0;
    ras_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seq_d   = seq_in;
          len_d   = level_clamped;
          cnt_d   = '0;
          timer_d = '0;
          ras_clr = 1'b1;
          state_d = (level_clamped == 4'd0) ? ST_DONE : ST_DRAW;
        end
      end
      ST_DRAW: begin
        ras_en = 1'b1;
        if (ras_last) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (timer_q == TW'(HOLD_CYCLES - 1)) begin
          timer_d = '0;
          state_d = ST_ERASE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ERASE: begin
        ras_en = 1'b1;
        if (ras_last) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          // Advancing the index here lets the next tile's first pixel share this boundary.
          if (cnt_q == 6'(len_q) - 6'd1) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + 6'd1;
            state_d = ST_DRAW;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    plot_d  = (state_d == ST_DRAW) || (state_d == ST_ERASE);
    blank_d = (state_d == ST_ERASE);
    busy_d  = (state_d == ST_DRAW) || (state_d == ST_HOLD) ||
              (state_d == ST_ERASE) || (state_d == ST_GAP);
    done_d  = (state_d == ST_DONE);
  end

  assign seq_out     = seq_q;
  assign counter     = cnt_q;
  assign x_off       = pixel[2:0];
  assign y_off       = pixel[5:3];
  assign plot        = plot_q;
  assign blank       = blank_q;
  assign busy        = busy_q;
  assign load_random = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_tile_playback_ctrl.sv
// Randomised bench for tile_playback_ctrl against a cycle-position model of the playback timeline.
module tb_tile_playback_ctrl;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int MAXT = 9;
  localparam int TILE = 128 + HOLD + GAP;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  level;
  logic [17:0] seq_in;
  logic [17:0] seq_out;
  logic [5:0]  counter;
  logic        load_random;
  logic [2:0]  x_off, y_off;
  logic        blank, plot, busy, done;

  int tests_run    = 0;
  int tests_failed = 0;
  int plot_total;

  tile_playback_ctrl #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .MAX_TILES   (MAXT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .level       (level),
    .seq_in      (seq_in),
    .seq_out     (seq_out),
    .counter     (counter),
    .load_random (load_random),
    .x_off       (x_off),
    .y_off       (y_off),
    .blank       (blank),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observed();
    return {29'd0, seq_out, counter, load_random, x_off, y_off, blank, plot, busy, done};
  endfunction

  function automatic logic [63:0] pack(input logic [17:0] s, input int cnt, input bit lr,
                                       input int x, input int y, input bit bl, input bit pl,
                                       input bit bz, input bit dn);
    return {29'd0, s, 6'(cnt), lr, 3'(x), 3'(y), bl, pl, bz, dn};
  endfunction

  // Expected outputs t cycles after the start edge, for n tiles of sequence s.
  function automatic logic [63:0] expect_out(input int t, input int n, input logic [17:0] s);
    int total, tile, w, last_idx;
    total    = (n == 0) ? 1 : n * TILE + 1;
    last_idx = (n == 0) ? 0 : n - 1;
    if (t == total) return pack(s, last_idx, 0, 0, 0, 0, 0, 0, 1);
    if (t > total)  return pack(s, last_idx, 0, 0, 0, 0, 0, 0, 0);
    tile = (t - 1) / TILE;
    w    = (t - 1) % TILE;
    if (w < 64)            return pack(s, tile, 1, w % 8, w / 8, 0, 1, 1, 0);
    if (w < 64 + HOLD)     return pack(s, tile, 1, 0, 0, 0, 0, 1, 0);
    if (w < 128 + HOLD)    return pack(s, tile, 1, (w - 64 - HOLD) % 8, (w - 64 - HOLD) / 8, 1, 1, 1, 0);
    return pack(s, tile, 1, 0, 0, 0, 0, 1, 0);
  endfunction

  // One playback; optional mid-run disturbance (dist_at) or reset (rst_at) at a given cycle.
  task automatic run(input string tag, input logic [17:0] s, input logic [3:0] lvl,
                     input int dist_at, input int rst_at, input int exp_plots);
    int n, total, plots;
    n     = (lvl > 4'(MAXT)) ? MAXT : int'(lvl);
    total = (n == 0) ? 1 : n * TILE + 1;
    plots = 0;
    @(negedge clock);
    seq_in = s;
    level  = lvl;
    start  = 1'b1;
    for (int t = 1; t <= total + 2; t++) begin
      @(negedge clock);
      start = 1'b0;
      check(tag, observed(), expect_out(t, n, s));
      if (plot) plots++;
      if (t == rst_at) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check({tag, "_reset"}, observed(), 64'd0);
        return;
      end
      if (t == dist_at) begin
        seq_in = 18'($urandom);
        level  = 4'($urandom);
        start  = 1'b1;
      end
    end
    if (exp_plots >= 0) check({tag, "_plots"}, 64'(plots), 64'(exp_plots));
  endtask

  // start held high with one tile: runs repeat every TILE+2 cycles.
  task automatic back_to_back(input logic [17:0] s);
    int period, local_t;
    period = TILE + 2;
    @(negedge clock);
    seq_in = s;
    level  = 4'd1;
    start  = 1'b1;
    for (int t = 1; t <= 3 * period - 1; t++) begin
      @(negedge clock);
      local_t = (t - 1) % period + 1;
      check("b2b", observed(), expect_out(local_t, 1, s));
    end
    start = 1'b0;
    @(negedge clock);
    check("b2b_idle", observed(), expect_out(TILE + 2, 1, s));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    level  = 4'd0;
    seq_in = 18'd0;
    repeat (3) @(negedge clock);
    check("reset_state", observed(), 64'd0);
    reset = 1'b0;

    run("single", 18'b10_0000_0000_0000_0000, 4'd1, 0, 0, 128);
    run("three", 18'($urandom), 4'd3, 0, 0, 384);
    run("level0", 18'($urandom), 4'd0, 0, 0, 0);
    run("level15", 18'($urandom), 4'd15, 0, 0, 9 * 128);
    run("stable_mid", 18'($urandom), 4'd4, 200, 0, 4 * 128);
    run("start_in_done", 18'($urandom), 4'd2, 2 * TILE + 1, 0, 2 * 128);
    run("reset_mid", 18'($urandom), 4'd3, 0, TILE + 31, -1);
    run("after_reset", 18'($urandom), 4'd2, 0, 0, 2 * 128);

    for (int r = 0; r < 4; r++) begin
      logic [3:0] lv;
      int d;
      lv = 4'($urandom_range(0, 15));
      d  = $urandom_range(2, 300);
      run("random", 18'($urandom), lv, d, 0, -1);
    end

    back_to_back(18'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
